// File: rtl/seven_seg_scan_decoder_if.sv
// Display-bus monitor interface: scanned active-low anode/segment inputs
// and the reconstructed HH:MM:SS time with its status pulses.
interface seven_seg_scan_decoder_if;
  logic [7:0]  AN;
  logic [6:0]  SevenSeg;
  logic [23:0] time_bcd;
  logic        frame_valid;
  logic        range_err;
  logic        seg_err;
  logic        stale;

  modport master (
    output AN, SevenSeg,
    input  time_bcd, frame_valid, range_err, seg_err, stale
  );

  modport slave (
    input  AN, SevenSeg,
    output time_bcd, frame_valid, range_err, seg_err, stale
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Samples an asynchronous multiplexed seven-segment scan bus and rebuilds the
// six BCD time digits, flagging malformed patterns, illegal times and a stalled scan.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 100000
) (
  input logic                     CLK,
  input logic                     RST,
  seven_seg_scan_decoder_if.slave bus
);

  localparam int unsigned AN_W  = 8;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned PAT_W = AN_W + SEG_W;
  localparam int unsigned STB_W = 8;
  localparam int unsigned TMO_W = 24;
  localparam int unsigned NDIG  = 6;
  localparam int unsigned BCD_W = 4 * NDIG;

  localparam logic [STB_W-1:0] STB_MAX = '1;
  localparam logic [STB_W-1:0] STB_TGT = STB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_TGT = TMO_W'(TIMEOUT);

  logic [PAT_W-1:0] sync1, sync2, pat_prev;
  logic [STB_W-1:0] stb_cnt, stb_nxt;
  logic             armed;
  logic [BCD_W-1:0] shadow;
  logic [NDIG-1:0]  seen, seen_base, cap_mask;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

  logic [BCD_W-1:0] time_bcd_q;
  logic             frame_valid_q, range_err_q, seg_err_q, stale_q;

  logic [AN_W-1:0]  an_s;
  logic [SEG_W-1:0] seg_s;
  logic             changed, settled, idle, an_one_hot, code_ok, cap, bad, frame_done;
  logic [2:0]       pos;
  logic [3:0]       digit;

  assign an_s  = sync2[PAT_W-1 -: AN_W];
  assign seg_s = sync2[SEG_W-1:0];

  function automatic logic range_bad(input logic [BCD_W-1:0] t);
    return (t[7:4] > 4'd5) || (t[15:12] > 4'd5) || (t[23:20] > 4'd2) ||
           ((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
  endfunction

  // Hold counter counts the cycles S has shown its current value, so a pattern
  // is settled on the edge its hold reaches STABLE_CYCLES.
  always_comb begin : p_settle
    changed = (sync2 != pat_prev);
    if (changed) begin
      stb_nxt = STB_W'(1);
    end else if (stb_cnt == STB_MAX) begin
      stb_nxt = stb_cnt;
    end else begin
      stb_nxt = stb_cnt + STB_W'(1);
    end
    settled = (stb_nxt == STB_TGT) && (armed || changed);
  end

  // Anode position and segment-code decode of the synchronised pattern.
  always_comb begin : p_decode
    pos        = 3'd0;
    an_one_hot = 1'b0;
    case (an_s)
      8'b1111_1011: begin pos = 3'd0; an_one_hot = 1'b1; end
      8'b1111_0111: begin pos = 3'd1; an_one_hot = 1'b1; end
      8'b1110_1111: begin pos = 3'd2; an_one_hot = 1'b1; end
      8'b1101_1111: begin pos = 3'd3; an_one_hot = 1'b1; end
      8'b1011_1111: begin pos = 3'd4; an_one_hot = 1'b1; end
      8'b0111_1111: begin pos = 3'd5; an_one_hot = 1'b1; end
      default:      ;
    endcase

    digit   = 4'd0;
    code_ok = 1'b1;
    case (seg_s)
      7'b0000001: digit = 4'd0;
      7'b1001111: digit = 4'd1;
      7'b0010010: digit = 4'd2;
      7'b0000110: digit = 4'd3;
      7'b1001100: digit = 4'd4;
      7'b0100100: digit = 4'd5;
      7'b0100000: digit = 4'd6;
      7'b0001111: digit = 4'd7;
      7'b0000000: digit = 4'd8;
      7'b0000100: digit = 4'd9;
      default:    code_ok = 1'b0;
    endcase

    idle     = (an_s == '1);
    cap      = settled && an_one_hot && code_ok;
    bad      = settled && !idle && !(an_one_hot && code_ok);
    cap_mask = cap ? (NDIG'(1) << pos) : '0;
  end

  // A full seen set publishes the frame; a capture on that edge starts the next one.
  always_comb begin : p_frame
    frame_done = (seen == '1);
    seen_base  = frame_done ? '0 : seen;
    if (frame_done) begin
      tmo_nxt = '0;
    end else if (tmo_cnt == TMO_TGT) begin
      tmo_nxt = tmo_cnt;
    end else begin
      tmo_nxt = tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin : p_regs
    if (RST) begin
      sync1         <= '0;
      sync2         <= '0;
      pat_prev      <= '0;
      stb_cnt       <= '0;
      armed         <= 1'b1;
      shadow        <= '0;
      seen          <= '0;
      tmo_cnt       <= '0;
      time_bcd_q    <= '0;
      frame_valid_q <= 1'b0;
      range_err_q   <= 1'b0;
      seg_err_q     <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      sync1    <= {bus.AN, bus.SevenSeg};
      sync2    <= sync1;
      pat_prev <= sync2;
      stb_cnt  <= stb_nxt;

      if (settled) begin
        armed <= 1'b0;
      end else if (changed) begin
        armed <= 1'b1;
      end

      if (cap) begin
        shadow[{pos, 2'b00} +: 4] <= digit;
      end
      seen <= seen_base | cap_mask;

      if (frame_done) begin
        time_bcd_q <= shadow;
      end
      frame_valid_q <= frame_done;
      range_err_q   <= frame_done && range_bad(shadow);
      seg_err_q     <= bad;

      tmo_cnt <= tmo_nxt;
      stale_q <= (tmo_nxt == TMO_TGT);
    end
  end

  assign bus.time_bcd    = time_bcd_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.range_err   = range_err_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: table-driven scan vectors feed a timed
// scoreboard of expected frames and segment errors; stale is tracked every cycle.
module tb_seven_seg_scan_decoder;

  localparam int unsigned STB = 4;
  localparam int unsigned TMO = 64;

  typedef enum logic [1:0] {K_NONE, K_CAP, K_SEG} kind_e;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    int         hold;
    kind_e      kind;
    int         pos;
    int         digit;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [23:0] bcd;
    logic        rng;
  } frm_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  seven_seg_scan_decoder_if bus();

  seven_seg_scan_decoder #(.STABLE_CYCLES(STB), .TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int   cyc       = 0;
  int   checks    = 0;
  int   fails     = 0;
  int   clear_cyc = 0;
  frm_t frame_q[$];
  int   seg_q[$];
  frm_t fe;
  int   se;
  vec_t tbl[$];

  logic [23:0] m_shadow;
  logic [5:0]  m_seen;
  logic [14:0] m_prev;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic range_bad(input logic [23:0] t);
    return (t[7:4] > 4'd5) || (t[15:12] > 4'd5) || (t[23:20] > 4'd2) ||
           ((t[23:20] == 4'd2) && (t[19:16] > 4'd3));
  endfunction

  function automatic logic [6:0] code(input int d);
    case (d)
      0:       code = 7'b0000001;
      1:       code = 7'b1001111;
      2:       code = 7'b0010010;
      3:       code = 7'b0000110;
      4:       code = 7'b1001100;
      5:       code = 7'b0100100;
      6:       code = 7'b0100000;
      7:       code = 7'b0001111;
      8:       code = 7'b0000000;
      9:       code = 7'b0000100;
      default: code = 7'b1111111;
    endcase
  endfunction

  function automatic vec_t dv(input int pos, input int d, input int hold);
    vec_t v;
    v.an          = 8'hFF;
    v.an[pos + 2] = 1'b0;
    v.seg         = code(d);
    v.hold        = hold;
    v.kind        = K_CAP;
    v.pos         = pos;
    v.digit       = d;
    return v;
  endfunction

  function automatic vec_t raw(input logic [7:0] an, input logic [6:0] seg, input int hold,
                               input kind_e k);
    vec_t v;
    v.an    = an;
    v.seg   = seg;
    v.hold  = hold;
    v.kind  = k;
    v.pos   = 0;
    v.digit = 0;
    return v;
  endfunction

  // Queue a full in-order scan (sec units first) of a BCD time.
  task automatic push_time(input logic [23:0] t, input int hold);
    for (int p = 0; p < 6; p++) tbl.push_back(dv(p, int'(t[p*4 +: 4]), hold));
  endtask

  // Drive one pattern and predict the events it must cause.
  task automatic apply(input vec_t v);
    logic [14:0] p;
    kind_e       k;
    frm_t        f;
    @(negedge CLK);
    bus.AN       = v.an;
    bus.SevenSeg = v.seg;
    p      = {v.an, v.seg};
    k      = ((p != m_prev) && (v.hold >= int'(STB))) ? v.kind : K_NONE;
    m_prev = p;
    if (k == K_SEG) seg_q.push_back(cyc + int'(STB) + 2);
    if (k == K_CAP) begin
      m_shadow[v.pos*4 +: 4] = 4'(v.digit);
      m_seen[v.pos]          = 1'b1;
      if (m_seen == 6'h3F) begin
        f.cyc = cyc + int'(STB) + 3;
        f.bcd = m_shadow;
        f.rng = range_bad(m_shadow);
        frame_q.push_back(f);
        m_seen = '0;
      end
    end
    repeat (v.hold) @(posedge CLK);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic drain_check(input string name);
    repeat (int'(STB) + 10) @(posedge CLK);
    @(negedge CLK);
    chk({name, "_frames_missing"}, 24'(frame_q.size()), 24'd0);
    chk({name, "_segerr_missing"}, 24'(seg_q.size()), 24'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    RST          = 1'b1;
    bus.AN       = 8'hFF;
    bus.SevenSeg = 7'h7F;
    repeat (n) @(negedge CLK);
    chk("rst_time_bcd", bus.time_bcd, 24'h0);
    chk("rst_frame_valid", 24'(bus.frame_valid), 24'h0);
    chk("rst_range_err", 24'(bus.range_err), 24'h0);
    chk("rst_seg_err", 24'(bus.seg_err), 24'h0);
    chk("rst_stale", 24'(bus.stale), 24'h0);
    m_shadow = '0;
    m_seen   = '0;
    m_prev   = {8'hFF, 7'h7F};
    RST      = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every pulse and tracks stale each cycle.
  always @(posedge CLK) begin
    cyc++;
    #1;
    if (RST) begin
      clear_cyc = cyc;
    end else begin
      checks++;
      if (bus.range_err && !bus.frame_valid) begin
        fails++;
        $display("FAIL range_err_alone: range_err=1 with frame_valid=0 (cycle %0d)", cyc);
      end
      if (bus.frame_valid) begin
        if (frame_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL frame_unexpected: time_bcd=%h (cycle %0d)", bus.time_bcd, cyc);
        end else begin
          fe = frame_q.pop_front();
          chk("frame_cycle", 24'(cyc), 24'(fe.cyc));
          chk("time_bcd", bus.time_bcd, fe.bcd);
          chk("range_err", 24'(bus.range_err), 24'(fe.rng));
          clear_cyc = fe.cyc;
        end
      end
      if (bus.seg_err) begin
        if (seg_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL seg_err_unexpected: seg_err=1 (cycle %0d)", cyc);
        end else begin
          se = seg_q.pop_front();
          chk("seg_err_cycle", 24'(cyc), 24'(se));
        end
      end
      chk("stale", 24'(bus.stale), 24'((cyc - clear_cyc) >= int'(TMO)));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.AN       = 8'hFF;
    bus.SevenSeg = 7'h7F;
    m_shadow     = '0;
    m_seen       = '0;
    m_prev       = {8'hFF, 7'h7F};
    do_reset(3);
    apply(raw(8'hFF, 7'h7F, 10, K_NONE));

    // Clean scan, then legal/illegal time frames exercising every digit code.
    push_time(24'h123456, 10);
    push_time(24'h235959, 4);
    push_time(24'h240000, 10);
    push_time(24'h180607, 10);
    push_time(24'h256109, 10);
    push_time(24'h300000, 4);
    push_time(24'h006000, 10);
    push_time(24'h000060, 10);
    run_tbl();
    drain_check("frames");

    // Patterns held one cycle short of settling must never capture.
    push_time(24'h214365, 3);
    tbl.push_back(raw(8'hFF, 7'h7F, 10, K_NONE));
    run_tbl();
    drain_check("glitch");

    // Malformed patterns between partial captures leave seen untouched.
    for (int p = 1; p < 6; p++) tbl.push_back(dv(p, int'(p == 5 ? 2 : p == 4 ? 3 : p == 2 ? 9 : 5), 10));
    tbl.push_back(raw(8'b1111_1011, 7'b1111111, 10, K_SEG));
    tbl.push_back(raw(8'b1111_0011, code(4), 10, K_SEG));
    tbl.push_back(raw(8'b1111_1111, 7'h7F, 10, K_NONE));
    tbl.push_back(raw(8'b1111_1110, code(1), 10, K_SEG));
    tbl.push_back(raw(8'b1111_0111, 7'b1111110, 10, K_SEG));
    tbl.push_back(raw(8'b1111_1011, 7'b0110000, 10, K_SEG));
    tbl.push_back(dv(0, 8, 10));
    run_tbl();
    drain_check("bad_pat");

    // Repeat capture overwrites, remaining positions out of order.
    apply(dv(0, 3, 10));
    apply(dv(0, 7, 10));
    apply(dv(5, 1, 10));
    apply(dv(3, 2, 10));
    apply(dv(1, 4, 10));
    apply(dv(4, 0, 10));
    apply(dv(2, 5, 10));
    drain_check("repeat");
    chk("repeat_sec_units", {20'h0, bus.time_bcd[3:0]}, 24'h7);
    chk("repeat_time", bus.time_bcd, 24'h102547);

    // Scan stops long enough for stale to rise, then a new frame clears it.
    apply(raw(8'hFF, 7'h7F, 80, K_NONE));
    chk("stale_after_stop", 24'(bus.stale), 24'h1);
    push_time(24'h235959, 4);
    run_tbl();
    drain_check("stale");
    chk("stale_cleared", 24'(bus.stale), 24'h0);

    // Reset mid-frame discards partial captures.
    apply(dv(0, 1, 10));
    apply(dv(1, 2, 10));
    apply(dv(2, 3, 10));
    do_reset(3);
    apply(dv(3, 4, 10));
    apply(dv(4, 5, 10));
    apply(dv(5, 0, 10));
    drain_check("rst_partial");
    apply(dv(0, 9, 10));
    apply(dv(1, 1, 10));
    apply(dv(2, 2, 10));
    drain_check("rst_full");
    chk("rst_frame_time", bus.time_bcd, 24'h054219);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
